mrf_spi_responder: RTL and testbench

- SPI slave model of the RF transceiver's register interface: the responder end of the RF SPI link (mode 0, MSB first, active-low cs).
- Decodes short/long-address read and write frames, holds a short and a long register file, drives sdo read data, and raises an active-low interrupt.
- Used as a loopback/emulation target so the RF controller and serial buffer run on hardware without the radio fitted.

---
 rtl/mrf_spi_responder.sv | 216 +++++++++++++++++++++
 tb/tb_mrf_spi_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mrf_spi_responder.sv
// SPI mode-0 responder emulating the RF transceiver register interface:
// short/long register files, read-to-clear interrupt status, and a write strobe.
module mrf_spi_responder #(
   parameter int         LONG_AW      = 10,
   parameter logic [5:0] INTSTAT_ADDR = 6'h31,
   parameter logic [5:0] INTCON_ADDR  = 6'h32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       cs,
   input  logic       sdi,
   output logic       sdo,
   output logic       intr_n,
   input  logic [7:0] irq_set,
   output logic       wr_valid,
   output logic       wr_long,
   output logic [9:0] wr_addr,
   output logic [7:0] wr_data
);

   typedef enum logic [2:0] {IDLE, CMD, LHDR, SDATA, LDATA, DONE} state_t;

   logic [2:0] sck_sync_q;
   logic [1:0] cs_sync_q, sdi_sync_q;
   logic       sck_rise, sck_fall, cs_n, sdi_s;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [6:0] sh_q, sh_d;
   logic [9:0] addr_q, addr_d;
   logic       long_q, long_d;
   logic       rw_q, rw_d;
   logic       load_q, load_d;
   logic [7:0] tx_q, tx_d;
   logic       sdo_q, sdo_d;
   logic       intr_n_q, intr_n_d;
   logic       wr_valid_q, wr_valid_d;
   logic       wr_long_q, wr_long_d;
   logic [9:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic [7:0] sreg_q [64];
   logic [7:0] sreg_d [64];

   logic [7:0]         mem_q [2**LONG_AW];
   logic [7:0]         mem_rdata_q;
   logic [LONG_AW-1:0] mem_raddr, laddr;
   logic               mem_we;
   logic [7:0]         clr;
   logic [7:0]         rx_byte;

   // sck edges are taken from the second sync stage against a third, aligned with cs/sdi
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync_q <= 3'b000;
         cs_sync_q  <= 2'b11;
         sdi_sync_q <= 2'b00;
      end else begin
         sck_sync_q <= {sck_sync_q[1:0], sck};
         cs_sync_q  <= {cs_sync_q[0], cs};
         sdi_sync_q <= {sdi_sync_q[0], sdi};
      end
   end

   assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
   assign cs_n      = cs_sync_q[1];
   assign sdi_s     = sdi_sync_q[1];
   assign rx_byte   = {sh_q, sdi_s};
   assign laddr     = addr_q[LONG_AW-1:0];
   assign mem_raddr = addr_d[LONG_AW-1:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      addr_d     = addr_q;
      long_d     = long_q;
      rw_d       = rw_q;
      load_d     = 1'b0;
      tx_d       = tx_q;
      sdo_d      = sdo_q;
      wr_valid_d = 1'b0;
      wr_long_d  = wr_long_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      sreg_d     = sreg_q;
      mem_we     = 1'b0;
      clr        = 8'h00;

      if (load_q) tx_d = long_q ? mem_rdata_q : sreg_q[addr_q[5:0]];

      if (cs_n) begin
         state_d = IDLE;
         sdo_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = CMD;
               cnt_d   = 3'd0;
            end
            CMD: if (sck_rise) begin
               sh_d  = rx_byte[6:0];
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  if (!rx_byte[7]) begin
                     long_d  = 1'b0;
                     addr_d  = {4'b0000, rx_byte[6:1]};
                     rw_d    = rx_byte[0];
                     load_d  = 1'b1;
                     state_d = SDATA;
                  end else begin
                     long_d  = 1'b1;
                     addr_d  = {rx_byte[6:0], 3'b000};
                     state_d = LHDR;
                  end
               end
            end
            LHDR: if (sck_rise) begin
               sh_d  = rx_byte[6:0];
               cnt_d = cnt_q + 3'd1;
               // 4th bit of the second header byte carries R/W; low address bits precede it
               if (cnt_q == 3'd3) begin
                  addr_d[2:0] = sh_q[2:0];
                  rw_d        = sdi_s;
                  load_d      = 1'b1;
               end
               if (cnt_q == 3'd7) state_d = LDATA;
            end
            SDATA, LDATA: begin
               if (sck_rise) begin
                  sh_d  = rx_byte[6:0];
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     state_d = DONE;
                     sdo_d   = 1'b0;
                     if (rw_q) begin
                        wr_valid_d = 1'b1;
                        wr_long_d  = long_q;
                        wr_data_d  = rx_byte;
                        if (long_q) begin
                           wr_addr_d = 10'(laddr);
                           mem_we    = 1'b1;
                        end else begin
                           wr_addr_d = addr_q;
                           if (addr_q[5:0] != INTSTAT_ADDR) sreg_d[addr_q[5:0]] = rx_byte;
                        end
                     end else if (!long_q && addr_q[5:0] == INTSTAT_ADDR) begin
                        clr = 8'hFF;
                     end
                  end
               end
               if (sck_fall && !rw_q) begin
                  sdo_d = tx_q[7];
                  tx_d  = {tx_q[6:0], 1'b0};
               end
            end
            default: ;
         endcase
      end

      // a set pulse in the clearing cycle survives because it is ORed in last
      sreg_d[INTSTAT_ADDR] = (sreg_q[INTSTAT_ADDR] & ~clr) | irq_set;
      intr_n_d = ~|(sreg_q[INTSTAT_ADDR] & ~sreg_q[INTCON_ADDR]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         sh_q       <= 7'd0;
         addr_q     <= 10'd0;
         long_q     <= 1'b0;
         rw_q       <= 1'b0;
         load_q     <= 1'b0;
         tx_q       <= 8'h00;
         sdo_q      <= 1'b0;
         intr_n_q   <= 1'b1;
         wr_valid_q <= 1'b0;
         wr_long_q  <= 1'b0;
         wr_addr_q  <= 10'd0;
         wr_data_q  <= 8'h00;
         for (int i = 0; i < 64; i++) sreg_q[i] <= (6'(i) == INTCON_ADDR) ? 8'hFF : 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         addr_q     <= addr_d;
         long_q     <= long_d;
         rw_q       <= rw_d;
         load_q     <= load_d;
         tx_q       <= tx_d;
         sdo_q      <= sdo_d;
         intr_n_q   <= intr_n_d;
         wr_valid_q <= wr_valid_d;
         wr_long_q  <= wr_long_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         sreg_q     <= sreg_d;
      end
   end

   // long memory: unreset, synchronous read
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[laddr] <= wr_data_d;
      mem_rdata_q <= mem_q[mem_raddr];
   end

   assign sdo      = sdo_q;
   assign intr_n   = intr_n_q;
   assign wr_valid = wr_valid_q;
   assign wr_long  = wr_long_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_mrf_spi_responder.sv
// Bench for mrf_spi_responder: a mode-0 SPI master drives table-driven frames,
// committed writes are checked against a queue, and interrupt/abort/reset cases run by hand.
module tb_mrf_spi_responder;

   logic       clk = 1'b0;
   logic       rst, sck, cs, sdi;
   logic [7:0] irq_set;
   logic       sdo, intr_n, wr_valid, wr_long;
   logic [9:0] wr_addr;
   logic [7:0] wr_data;

   always #5 clk = ~clk;

   mrf_spi_responder dut (
      .clk(clk), .rst(rst), .sck(sck), .cs(cs), .sdi(sdi), .sdo(sdo), .intr_n(intr_n),
      .irq_set(irq_set), .wr_valid(wr_valid), .wr_long(wr_long), .wr_addr(wr_addr),
      .wr_data(wr_data)
   );

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic       lng;
      logic [9:0] addr;
      logic [7:0] data;
   } wr_t;
   wr_t exp_q[$];

   typedef struct {
      string       name;
      logic [23:0] frame;
      int          nbits;
      bit          is_wr;
      logic        lng;
      logic [9:0]  addr;
      logic [7:0]  data;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   function automatic logic [23:0] sw(input logic [5:0] a, input logic [7:0] d);
      return {8'h00, 1'b0, a, 1'b1, d};
   endfunction
   function automatic logic [23:0] sr(input logic [5:0] a);
      return {8'h00, 1'b0, a, 1'b0, 8'h00};
   endfunction
   function automatic logic [23:0] lw(input logic [9:0] a, input logic [7:0] d);
      return {1'b1, a, 1'b1, 4'h0, d};
   endfunction
   function automatic logic [23:0] lr(input logic [9:0] a);
      return {1'b1, a, 1'b0, 4'h0, 8'h00};
   endfunction

   function automatic vec_t mk(input string nm, input logic [23:0] f, input int n, input bit w,
                               input logic lg, input logic [9:0] a, input logic [7:0] d);
      vec_t v;
      v.name = nm; v.frame = f; v.nbits = n; v.is_wr = w; v.lng = lg; v.addr = a; v.data = d;
      return v;
   endfunction

   task automatic half();
      repeat (5) @(negedge clk);
   endtask

   task automatic cs_low();
      cs = 1'b0;
      half();
   endtask

   task automatic cs_high();
      half();
      cs  = 1'b1;
      sdi = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic xfer_bit(input logic b);
      sdi = b;
      half();
      sck = 1'b1;
      half();
      sck = 1'b0;
   endtask

   // Full frame; rx holds the last 8 bits sampled on sck rises. With coincide set,
   // irq_set=0x01 is pulsed in the clk where the DUT sees the final rise.
   task automatic frame(input logic [23:0] v, input int n, input bit coincide, output logic [7:0] rx);
      rx = 8'h00;
      cs_low();
      for (int i = n - 1; i >= 0; i--) begin
         sdi = v[i];
         half();
         sck = 1'b1;
         rx  = {rx[6:0], sdo};
         if (i == 0 && coincide) begin
            repeat (2) @(negedge clk);
            irq_set = 8'h01;
            @(negedge clk);
            irq_set = 8'h00;
            repeat (2) @(negedge clk);
         end else begin
            half();
         end
         sck = 1'b0;
      end
      cs_high();
   endtask

   task automatic wr_short(input logic [5:0] a, input logic [7:0] d);
      logic [7:0] rx;
      exp_q.push_back({1'b0, {4'h0, a}, d});
      frame(sw(a, d), 16, 1'b0, rx);
   endtask

   task automatic rd_short(input string name, input logic [5:0] a, input logic [7:0] exp);
      logic [7:0] rx;
      frame(sr(a), 16, 1'b0, rx);
      chk(name, rx, exp);
   endtask

   task automatic pulse_irq(input logic [7:0] v);
      irq_set = v;
      @(negedge clk);
      irq_set = 8'h00;
   endtask

   always @(negedge clk) begin : wr_monitor
      wr_t e;
      if (!rst && wr_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL wr_spurious: got wr_valid addr %0h data %0h, required none", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            chk("wr_long", wr_long, e.lng);
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[$];
      logic [7:0]  rx;
      logic [23:0] v;

      rst = 1'b1; sck = 1'b0; cs = 1'b1; sdi = 1'b0; irq_set = 8'h00;
      repeat (4) @(negedge clk);
      chk("rst_sdo", sdo, 1'b0);
      chk("rst_intr_n", intr_n, 1'b1);
      chk("rst_wr_valid", wr_valid, 1'b0);
      chk("rst_wr_long", wr_long, 1'b0);
      chk("rst_wr_addr", wr_addr, 10'h000);
      chk("rst_wr_data", wr_data, 8'h00);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_intr_n", intr_n, 1'b1);

      tbl.push_back(mk("sw_0a",      sw(6'h0A, 8'h15),   16, 1'b1, 1'b0, 10'h00A, 8'h15));
      tbl.push_back(mk("rd_0a",      sr(6'h0A),          16, 1'b0, 1'b0, 10'h00A, 8'h15));
      tbl.push_back(mk("lw_3ff",     lw(10'h3FF, 8'hA5), 24, 1'b1, 1'b1, 10'h3FF, 8'hA5));
      tbl.push_back(mk("rd_l3ff",    lr(10'h3FF),        24, 1'b0, 1'b1, 10'h3FF, 8'hA5));
      tbl.push_back(mk("rd_3f",      sr(6'h3F),          16, 1'b0, 1'b0, 10'h03F, 8'h00));
      tbl.push_back(mk("sw_20",      sw(6'h20, 8'h5A),   16, 1'b1, 1'b0, 10'h020, 8'h5A));
      tbl.push_back(mk("rd_20",      sr(6'h20),          16, 1'b0, 1'b0, 10'h020, 8'h5A));
      tbl.push_back(mk("lw_001",     lw(10'h001, 8'h3C), 24, 1'b1, 1'b1, 10'h001, 8'h3C));
      tbl.push_back(mk("rd_l001",    lr(10'h001),        24, 1'b0, 1'b1, 10'h001, 8'h3C));
      tbl.push_back(mk("rd_l3ff_b",  lr(10'h3FF),        24, 1'b0, 1'b1, 10'h3FF, 8'hA5));
      tbl.push_back(mk("rd_intcon",  sr(6'h32),          16, 1'b0, 1'b0, 10'h032, 8'hFF));
      tbl.push_back(mk("sw_intstat", sw(6'h31, 8'hFF),   16, 1'b1, 1'b0, 10'h031, 8'hFF));
      tbl.push_back(mk("rd_intstat", sr(6'h31),          16, 1'b0, 1'b0, 10'h031, 8'h00));
      tbl.push_back(mk("rd_0a_b",    sr(6'h0A),          16, 1'b0, 1'b0, 10'h00A, 8'h15));

      foreach (tbl[k]) begin
         if (tbl[k].is_wr) exp_q.push_back({tbl[k].lng, tbl[k].addr, tbl[k].data});
         frame(tbl[k].frame, tbl[k].nbits, 1'b0, rx);
         if (!tbl[k].is_wr) chk(tbl[k].name, rx, tbl[k].data);
      end

      // interrupt masking, enable, read-to-clear
      pulse_irq(8'h08);
      repeat (4) @(negedge clk);
      chk("irq_masked_intr_n", intr_n, 1'b1);
      wr_short(6'h32, 8'hF7);
      repeat (3) @(negedge clk);
      chk("irq_unmasked_intr_n", intr_n, 1'b0);
      chk("wr_addr_hold", wr_addr, 10'h032);
      chk("wr_data_hold", wr_data, 8'hF7);
      rd_short("rd_intstat_08", 6'h31, 8'h08);
      chk("irq_cleared_intr_n", intr_n, 1'b1);
      rd_short("rd_intstat_clr", 6'h31, 8'h00);

      // set in the same clk as the clear
      wr_short(6'h32, 8'hF6);
      pulse_irq(8'h08);
      repeat (4) @(negedge clk);
      chk("coin_pre_intr_n", intr_n, 1'b0);
      frame(sr(6'h31), 16, 1'b1, rx);
      chk("coin_rd_intstat", rx, 8'h08);
      chk("coin_intr_n", intr_n, 1'b0);
      rd_short("coin_intstat_after", 6'h31, 8'h01);
      chk("coin_final_intr_n", intr_n, 1'b1);

      // aborted short write after 12 sck
      v = sw(6'h05, 8'h77);
      cs_low();
      for (int i = 15; i >= 4; i--) xfer_bit(v[i]);
      cs_high();
      rd_short("abort_rd_05", 6'h05, 8'h00);
      wr_short(6'h05, 8'h77);
      rd_short("after_abort_rd_05", 6'h05, 8'h77);

      // reset during the data phase of an INTCON read (0xF6, MSB set)
      pulse_irq(8'h08);
      repeat (4) @(negedge clk);
      chk("prerst_intr_n", intr_n, 1'b0);
      v = sr(6'h32);
      cs_low();
      for (int i = 15; i >= 8; i--) xfer_bit(v[i]);
      half();
      chk("prerst_sdo_bit7", sdo, 1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_sdo", sdo, 1'b0);
      chk("midrst_intr_n", intr_n, 1'b1);
      chk("midrst_wr_valid", wr_valid, 1'b0);
      rst = 1'b0;
      cs_high();
      rd_short("postrst_intcon", 6'h32, 8'hFF);
      rd_short("postrst_intstat", 6'h31, 8'h00);
      rd_short("postrst_0a", 6'h0A, 8'h00);
      wr_short(6'h0A, 8'h15);
      rd_short("postrst_rd_0a", 6'h0A, 8'h15);
      chk("postrst_intr_n", intr_n, 1'b1);

      repeat (5) @(negedge clk);
      chk("wr_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
